ahb_arb4: RTL and testbench
===========================

Name: ahb_arb4

Overview:
- 4-master round-robin arbiter for the AHB-Lite interconnect.
- Produces the one-hot address-phase select vector that drives the sel0..sel3 inputs of the 4:1 AND-OR master mux for HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT.
- Also produces a registered data-phase select vector for the HWDATA mux.
- Holds the grant across bursts and locked sequences, and parks on a default master when idle.

Parameters:
- DEF_MST, 2'd0, index of the park/default master (0..3).

Ports:
- hclk  input  1  bus clock; all state updates on its rising edge.
- hresetn  input  1  asynchronous active-low reset.
- req  input  4  bus request, bit n = master n.
- lock  input  4  HMASTLOCK request, bit n = master n.
- hready  input  1  HREADY from the slave-side response mux.
- htrans_sel  input  2  HTRANS of the currently granted master (address mux output).
- addr_sel  output  4  one-hot address-phase select to master mux.
- data_sel  output  4  one-hot data-phase select to HWDATA mux; all-zero means none.
- hmaster  output  2  binary index of the address-phase owner.
- hmastlock  output  1  lock qualifier for the current address phase.

Behaviour:
- Reset values (async, immediate on hresetn=0):
  - addr_sel = one-hot(DEF_MST); hmaster = DEF_MST; data_sel = 4'b0000; hmastlock = 0.
  - RR pointer = DEF_MST; state = PARK.
- Update rule: no register changes while hready=0. All updates below occur only at a rising edge with hready=1.
- data_sel <= addr_sel whenever hready=1, so the data phase lags the address phase by exactly one accepted transfer.
- States:
  - PARK: owner is DEF_MST, req=0.
  - OWN: owner has a request or an active burst.
  - LOCKED: lock[owner]=1.
- Hold condition: the grant is kept if any of the following is true, regardless of other requests:
  - state=LOCKED;
  - htrans_sel=BUSY(01);
  - htrans_sel=SEQ(11).
- Re-arbitration: when not held, the winner is chosen from req, searching in order ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - The winner becomes the owner next cycle.
  - ptr <= winner index.
  - hmaster = winner index.
- req=0 and not held: owner <= DEF_MST, state <= PARK, ptr unchanged.
- Transitions:
  - PARK→OWN: any req.
  - OWN→LOCKED: lock[owner]=1 at the arbitration edge.
  - LOCKED→OWN or PARK: lock[owner]=0 and htrans_sel is IDLE or NONSEQ; then re-arbitrate in the same edge.
- hmastlock: registered on hready=1 as lock[new owner].
- Latency: a request sampled at edge k, with hready=1 and no hold, appears on addr_sel after edge k (one cycle).
- Sole requester: if only the current owner requests, it retains the grant with no idle cycle.
- Owner drops req mid-burst (SEQ/BUSY): the grant is still held. No protocol checking.
- addr_sel is always exactly one-hot.
- hmaster must always encode addr_sel.
- Mid-operation reset returns all state to the reset values immediately.

Decomposition:
- Shared defines package ahb_defs:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ encodings;
  - arbiter state encodings PARK=2'd0, OWN=2'd1, LOCKED=2'd2.
- Natural sub-module rr_pick4: combinational rotate-priority picker.
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: gnt_oh[3:0], gnt_idx[1:0], any.
- ahb_arb4 contains the FSM, the ptr/owner/data_sel/hmastlock registers and the hold logic.

Test Plan:
- Reset with DEF_MST=0, then release; req=0 → addr_sel=0001, data_sel=0000, hmaster=0, hmastlock=0. Assert hresetn=0 mid-burst → same values immediately, without waiting for a clock edge.
- req=1111, hready=1, htrans_sel=NONSEQ every cycle, starting from ptr=0 → addr_sel sequence 0010, 0100, 1000, 0001, 0010. data_sel equals the previous addr_sel each cycle.
- Owner=1, htrans_sel=SEQ for 3 cycles, req=1101 → addr_sel stays 0010 for those 3 cycles. When htrans_sel=IDLE → addr_sel=0100.
- hready=0 for 2 cycles with req changing → addr_sel, data_sel, hmaster frozen. When hready returns to 1 → one arbitration step only.
- Master 3 with lock=1000 and req=1111 → owner 3 held, hmastlock=1, for all cycles with lock[3]=1. Drop lock with htrans_sel=IDLE → hmastlock=0 and addr_sel=0001.
- Only master 2 requests, continuously → addr_sel=0100 constant. When req drops to 0 → addr_sel=0001 (park), ptr still 2, so the next req=1111 grants master 3.

Source files
------------

// File: rtl/ahb_defs.sv
// Shared AHB-Lite encodings for the 4-master arbiter.
// Holds HTRANS codes, arbiter state enum and a one-hot helper.
package ahb_defs;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   typedef enum logic [1:0] {
      ST_PARK   = 2'd0,
      ST_OWN    = 2'd1,
      ST_LOCKED = 2'd2
   } arb_state_t;

   function automatic logic [3:0] onehot4(input logic [1:0] idx);
      logic [3:0] v;
      v = 4'b0000;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational rotate-priority picker for 4 requesters.
// Ports: req/ptr in; gnt_oh, gnt_idx, any out. Search order ptr+1..ptr.
module rr_pick4
   import ahb_defs::*;
(
   input  logic [3:0] req,
   input  logic [1:0] ptr,
   output logic [3:0] gnt_oh,
   output logic [1:0] gnt_idx,
   output logic       any
);

   logic [1:0] w_cand;

   // Walk from lowest to highest priority so the
   // highest-priority hit (ptr+1) is assigned last.
   always_comb begin
      gnt_idx = ptr;
      any     = 1'b0;
      w_cand  = ptr;
      for (int k = 3; k >= 0; k--) begin
         w_cand = ptr + 2'(k + 1);
         if (req[w_cand]) begin
            gnt_idx = w_cand;
            any     = 1'b1;
         end
      end
   end

   assign gnt_oh = any ? onehot4(gnt_idx) : 4'b0000;

endmodule

// File: rtl/ahb_arb4.sv
// 4-master round-robin AHB-Lite arbiter with burst/lock hold and park.
// Ports: hclk, hresetn, req, lock, hready, htrans_sel in; addr_sel, data_sel, hmaster, hmastlock out.
module ahb_arb4
   import ahb_defs::*;
#(
   parameter logic [1:0] DEF_MST = 2'd0
) (
   input  logic       hclk,
   input  logic       hresetn,
   input  logic [3:0] req,
   input  logic [3:0] lock,
   input  logic       hready,
   input  logic [1:0] htrans_sel,
   output logic [3:0] addr_sel,
   output logic [3:0] data_sel,
   output logic [1:0] hmaster,
   output logic       hmastlock
);

   arb_state_t r_state;
   logic [1:0] r_ptr;
   logic [1:0] r_owner;
   logic [3:0] r_dsel;
   logic       r_lock;

   arb_state_t w_nxt_state;
   logic [1:0] w_nxt_ptr;
   logic [1:0] w_nxt_owner;
   logic       w_held;
   logic [3:0] w_gnt_oh;
   logic [1:0] w_gnt_idx;
   logic       w_any;

   rr_pick4 u_pick (
      .req     (req),
      .ptr     (r_ptr),
      .gnt_oh  (w_gnt_oh),
      .gnt_idx (w_gnt_idx),
      .any     (w_any)
   );

   // A lock only holds while the owner keeps asserting it;
   // BUSY/SEQ hold the grant regardless of requests.
   always_comb begin
      w_held = ((r_state == ST_LOCKED) && lock[r_owner])
             || (htrans_sel == HTRANS_BUSY)
             || (htrans_sel == HTRANS_SEQ);
   end

   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         r_state <= ST_PARK;
         r_ptr   <= DEF_MST;
         r_owner <= DEF_MST;
         r_dsel  <= 4'b0000;
         r_lock  <= 1'b0;
      end else if (hready) begin
         r_state <= w_nxt_state;
         r_ptr   <= w_nxt_ptr;
         r_owner <= w_nxt_owner;
         r_dsel  <= onehot4(r_owner);
         r_lock  <= lock[w_nxt_owner];
      end
   end

   always_comb begin
      w_nxt_state = r_state;
      w_nxt_ptr   = r_ptr;
      w_nxt_owner = r_owner;
      if (w_held) begin
         if (lock[r_owner])
            w_nxt_state = ST_LOCKED;
         else if (r_state == ST_LOCKED)
            w_nxt_state = ST_OWN;
      end else if (w_any) begin
         w_nxt_owner = w_gnt_idx;
         w_nxt_ptr   = w_gnt_idx;
         w_nxt_state = lock[w_gnt_idx] ? ST_LOCKED : ST_OWN;
      end else begin
         // Park keeps ptr so fairness resumes where it left off.
         w_nxt_owner = DEF_MST;
         w_nxt_state = ST_PARK;
      end
   end

   always_comb begin
      addr_sel  = onehot4(r_owner);
      hmaster   = r_owner;
      data_sel  = r_dsel;
      hmastlock = r_lock;
   end

endmodule

// File: tb/tb_ahb_arb4.sv
// Self-checking bench for ahb_arb4: directed scenarios plus random traffic.
// Outputs compared each cycle against a behavioural round-robin model.
module tb_ahb_arb4;

   logic       hclk;
   logic       hresetn;
   logic [3:0] req;
   logic [3:0] lock;
   logic       hready;
   logic [1:0] htrans_sel;
   logic [3:0] addr_sel;
   logic [3:0] data_sel;
   logic [1:0] hmaster;
   logic       hmastlock;

   int n_tests;
   int n_fail;

   int m_owner;
   int m_ptr;
   bit m_locked;
   bit m_hml;
   int m_dsel;

   localparam int DEF = 0;

   ahb_arb4 #(.DEF_MST(2'd0)) dut (
      .hclk       (hclk),
      .hresetn    (hresetn),
      .req        (req),
      .lock       (lock),
      .hready     (hready),
      .htrans_sel (htrans_sel),
      .addr_sel   (addr_sel),
      .data_sel   (data_sel),
      .hmaster    (hmaster),
      .hmastlock  (hmastlock)
   );

   initial hclk = 1'b0;
   always #5 hclk = ~hclk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_owner  = DEF;
      m_ptr    = DEF;
      m_locked = 0;
      m_hml    = 0;
      m_dsel   = 0;
   endtask

   task automatic model_edge();
      bit held;
      bit found;
      int win;
      int c;
      if (!hready) return;
      held = (m_locked && lock[m_owner]) || (htrans_sel == 2'b01)
             || (htrans_sel == 2'b11);
      m_dsel = 1 << m_owner;
      if (held) begin
         m_locked = lock[m_owner];
      end else begin
         found = 0;
         win = 0;
         for (int i = 1; i <= 4; i++) begin
            c = (m_ptr + i) % 4;
            if (!found && req[c]) begin
               win = c;
               found = 1;
            end
         end
         if (found) begin
            m_owner  = win;
            m_ptr    = win;
            m_locked = lock[win];
         end else begin
            m_owner  = DEF;
            m_locked = 0;
         end
      end
      m_hml = lock[m_owner];
   endtask

   task automatic check_all();
      chk("addr_sel", 32'(addr_sel), 32'(1 << m_owner));
      chk("data_sel", 32'(data_sel), 32'(m_dsel));
      chk("hmaster", 32'(hmaster), 32'(m_owner));
      chk("hmastlock", 32'(hmastlock), 32'(m_hml));
   endtask

   task automatic step(input logic [3:0] rq, input logic [3:0] lk,
                       input logic hr, input logic [1:0] tr);
      @(negedge hclk);
      req = rq;
      lock = lk;
      hready = hr;
      htrans_sel = tr;
      @(posedge hclk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic async_reset(input string tag);
      @(negedge hclk);
      #2;
      hresetn = 1'b0;
      #1;
      model_reset();
      chk({tag, "_addr"}, 32'(addr_sel), 32'h1);
      chk({tag, "_data"}, 32'(data_sel), 32'h0);
      chk({tag, "_hm"}, 32'(hmaster), 32'h0);
      chk({tag, "_lock"}, 32'(hmastlock), 32'h0);
      @(negedge hclk);
      hresetn = 1'b1;
   endtask

   initial begin
      logic [3:0] exp_seq [5];
      exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      n_tests = 0;
      n_fail  = 0;
      hresetn = 1'b0;
      req = 4'b0;
      lock = 4'b0;
      hready = 1'b1;
      htrans_sel = 2'b00;
      model_reset();
      repeat (2) @(posedge hclk);
      #1;
      chk("rst_addr", 32'(addr_sel), 32'h1);
      chk("rst_data", 32'(data_sel), 32'h0);
      chk("rst_hm", 32'(hmaster), 32'h0);
      chk("rst_lock", 32'(hmastlock), 32'h0);
      @(negedge hclk);
      hresetn = 1'b1;

      step(4'b0000, 4'b0, 1'b1, 2'b00);
      chk("park_idle", 32'(addr_sel), 32'h1);

      for (int i = 0; i < 5; i++) begin
         step(4'b1111, 4'b0, 1'b1, 2'b10);
         chk("rr_seq", 32'(addr_sel), 32'(exp_seq[i]));
      end

      for (int i = 0; i < 3; i++) begin
         step(4'b1101, 4'b0, 1'b1, 2'b11);
         chk("burst_hold", 32'(addr_sel), 32'h2);
      end
      step(4'b1101, 4'b0, 1'b1, 2'b00);
      chk("burst_end", 32'(addr_sel), 32'h4);

      step(4'b0001, 4'b0, 1'b0, 2'b10);
      chk("stall_addr", 32'(addr_sel), 32'h4);
      step(4'b1000, 4'b0, 1'b0, 2'b10);
      chk("stall_addr", 32'(addr_sel), 32'h4);
      step(4'b1111, 4'b1000, 1'b1, 2'b10);
      chk("stall_exit", 32'(addr_sel), 32'h8);
      chk("lock_on", 32'(hmastlock), 32'h1);

      for (int i = 0; i < 3; i++) begin
         step(4'b1111, 4'b1000, 1'b1, 2'b10);
         chk("lock_hold", 32'(addr_sel), 32'h8);
      end
      step(4'b1111, 4'b0000, 1'b1, 2'b00);
      chk("lock_drop", 32'(addr_sel), 32'h1);
      chk("lock_off", 32'(hmastlock), 32'h0);

      for (int i = 0; i < 4; i++) begin
         step(4'b0100, 4'b0, 1'b1, 2'b10);
         chk("sole_req", 32'(addr_sel), 32'h4);
      end
      step(4'b0000, 4'b0, 1'b1, 2'b00);
      chk("sole_park", 32'(addr_sel), 32'h1);
      step(4'b1111, 4'b0, 1'b1, 2'b10);
      chk("ptr_kept", 32'(addr_sel), 32'h8);
      step(4'b1111, 4'b0, 1'b1, 2'b11);
      async_reset("midrst");

      for (int i = 0; i < 3000; i++) begin
         logic [3:0] rq;
         logic [3:0] lk;
         logic       hr;
         logic [1:0] tr;
         rq = 4'($urandom);
         lk = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
         hr = ($urandom_range(0, 4) != 0);
         tr = 2'($urandom);
         step(rq, lk, hr, tr);
         if (i == 1500) async_reset("rndrst");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
